// File: rtl/stim_pattern_gen.sv
// Five-channel pattern player: plays DEPTH-deep vector/hold memory once per start (or repeat_cnt+1 times with STIM_PATTERN_GEN_REPEAT_EN).
// Latency: first vector one cycle after start; all outputs registered. No backpressure: playback free-runs until done or abort.
module stim_pattern_gen #(
    parameter int          DEPTH      = 16,
    parameter int          HOLD_W     = 8,
    parameter logic [4:0]  IDLE_VALUE = 5'b00000,
    localparam int         AW         = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [4:0]        wr_data,
    input  logic [HOLD_W-1:0] wr_hold,
    input  logic [AW:0]       num_steps,
    input  logic              start,
    input  logic              abort,
`ifdef STIM_PATTERN_GEN_REPEAT_EN
    input  logic [7:0]        repeat_cnt,
`endif
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     step_idx,
    output logic [4:0]        ch_out,
    output logic              ch_valid
);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

    state_t              state;
    logic [4:0]          mem_data [DEPTH];
    logic [HOLD_W-1:0]   mem_hold [DEPTH];
    logic [AW:0]         num_q;
    logic [HOLD_W-1:0]   hold_cnt;
`ifdef STIM_PATTERN_GEN_REPEAT_EN
    logic [7:0]          rep_left;
`endif

    logic                wr_ok;
    logic                start_ok;
    logic                last_step;
    logic [AW-1:0]       next_idx;
    logic [4:0]          first_data;
    logic [HOLD_W-1:0]   first_hold;

    assign wr_ok     = wr_en && (state == S_IDLE);
    assign start_ok  = start && !abort && (state == S_IDLE) &&
                       (num_steps != '0) && (num_steps <= (AW+1)'(DEPTH));
    assign last_step = ({1'b0, step_idx} == (num_q - 1'b1));
    assign next_idx  = step_idx + 1'b1;

    // A write to step 0 in the start cycle must be visible as the first vector.
    assign first_data = (wr_ok && (wr_addr == '0)) ? wr_data : mem_data[0];
    assign first_hold = (wr_ok && (wr_addr == '0)) ? wr_hold : mem_hold[0];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_data[wr_addr] <= wr_data;
            mem_hold[wr_addr] <= wr_hold;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ch_out   <= IDLE_VALUE;
            busy     <= 1'b0;
            done     <= 1'b0;
            ch_valid <= 1'b0;
            step_idx <= '0;
            hold_cnt <= '0;
            num_q    <= '0;
`ifdef STIM_PATTERN_GEN_REPEAT_EN
            rep_left <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        state    <= S_PLAY;
                        num_q    <= num_steps;
                        step_idx <= '0;
                        ch_out   <= first_data;
                        hold_cnt <= first_hold;
                        ch_valid <= 1'b1;
                        busy     <= 1'b1;
`ifdef STIM_PATTERN_GEN_REPEAT_EN
                        rep_left <= repeat_cnt;
`endif
                    end
                end
                S_PLAY: begin
                    if (abort) begin
                        state    <= S_IDLE;
                        ch_out   <= IDLE_VALUE;
                        ch_valid <= 1'b0;
                        busy     <= 1'b0;
                        step_idx <= '0;
                        hold_cnt <= '0;
                    end else if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end else if (!last_step) begin
                        step_idx <= next_idx;
                        ch_out   <= mem_data[next_idx];
                        hold_cnt <= mem_hold[next_idx];
`ifdef STIM_PATTERN_GEN_REPEAT_EN
                    end else if (rep_left != '0) begin
                        // Wrap straight into the next pass with no idle cycle.
                        rep_left <= rep_left - 1'b1;
                        step_idx <= '0;
                        ch_out   <= mem_data[0];
                        hold_cnt <= mem_hold[0];
`endif
                    end else begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        ch_valid <= 1'b0;
                        ch_out   <= IDLE_VALUE;
                        step_idx <= '0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stim_pattern_gen.sv
// Scoreboard bench: stimulus pushes the expected vector stream, a negedge monitor pops and compares.
module tb_stim_pattern_gen;
    localparam int DEPTH  = 16;
    localparam int HOLD_W = 8;
    localparam int AW     = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [4:0]        wr_data = '0;
    logic [HOLD_W-1:0] wr_hold = '0;
    logic [AW:0]       num_steps = '0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
`ifdef STIM_PATTERN_GEN_REPEAT_EN
    logic [7:0]        repeat_cnt = '0;
`endif
    logic              busy, done, ch_valid;
    logic [AW-1:0]     step_idx;
    logic [4:0]        ch_out;

    stim_pattern_gen #(.DEPTH(DEPTH), .HOLD_W(HOLD_W), .IDLE_VALUE(5'b00000)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_hold(wr_hold), .num_steps(num_steps), .start(start), .abort(abort),
`ifdef STIM_PATTERN_GEN_REPEAT_EN
        .repeat_cnt(repeat_cnt),
`endif
        .busy(busy), .done(done), .step_idx(step_idx), .ch_out(ch_out), .ch_valid(ch_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]    data;
        logic [AW-1:0] idx;
        logic          fin;
    } exp_t;

    exp_t              exp_q[$];
    int                n_checks = 0;
    int                n_pass = 0;
    logic              pend_done = 1'b0;
    logic [4:0]        m_data [DEPTH];
    logic [HOLD_W-1:0] m_hold [DEPTH];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every cycle, compare the visible output against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            pend_done = 1'b0;
        end else begin
            chk("done", done, pend_done);
            pend_done = 1'b0;
            if (ch_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ch_out", ch_out, e.data);
                    chk("step_idx", step_idx, e.idx);
                    chk("busy", busy, 1);
                    pend_done = e.fin;
                end
            end else begin
                chk("idle_ch_out", ch_out, 0);
                chk("idle_busy", busy, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input int a, input int d, input int h);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = 5'(d); wr_hold = HOLD_W'(h);
        tick();
        wr_en = 1'b0;
        m_data[a] = 5'(d);
        m_hold[a] = HOLD_W'(h);
    endtask

    // n steps, reps passes; k>0 aborts after k visible vectors (-1 picks k at random);
    // mid_wr pokes a write plus a stray start during playback; sw writes step sa in the start cycle.
    task automatic play(input int n, input int k, input int reps, input bit mid_wr,
                        input bit sw, input int sa, input int sd, input int sh);
        exp_t L[$];
        exp_t e;
        int   kk;
        if (sw) begin
            wr_en = 1'b1; wr_addr = AW'(sa); wr_data = 5'(sd); wr_hold = HOLD_W'(sh);
            m_data[sa] = 5'(sd);
            m_hold[sa] = HOLD_W'(sh);
        end
        for (int r = 0; r < reps; r++)
            for (int s = 0; s < n; s++)
                for (int c = 0; c <= int'(m_hold[s]); c++) begin
                    e.data = m_data[s]; e.idx = AW'(s); e.fin = 1'b0;
                    L.push_back(e);
                end
        kk = (k < 0) ? $urandom_range(1, L.size()) : k;
        if (kk == 0) L[L.size()-1].fin = 1'b1;
        for (int i = 0; i < L.size() && (kk == 0 || i < kk); i++) exp_q.push_back(L[i]);
        num_steps = (AW+1)'(n);
        start = 1'b1;
`ifdef STIM_PATTERN_GEN_REPEAT_EN
        repeat_cnt = 8'(reps - 1);
`endif
        tick();
        start = 1'b0; wr_en = 1'b0;
        if (kk > 0) begin
            repeat (kk - 1) tick();
            abort = 1'b1;
            tick();
            abort = 1'b0;
            repeat (3) tick();
        end else if (mid_wr) begin
            wr_en = 1'b1; wr_addr = 4'd1; wr_data = 5'h15; wr_hold = 8'd0; start = 1'b1;
            tick();
            wr_en = 1'b0; start = 1'b0;
            repeat (L.size() + 2) tick();
        end else begin
            repeat (L.size() + 3) tick();
        end
    endtask

    task automatic nominal_load();
        write(0, 5'h01, 0);
        write(1, 5'h1F, 2);
        write(2, 5'h0A, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int reps_max;
`ifdef STIM_PATTERN_GEN_REPEAT_EN
        reps_max = 3;
`else
        reps_max = 1;
`endif
        repeat (3) tick();
        chk("rst_ch_out", ch_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", ch_valid, 0);
        chk("rst_step_idx", step_idx, 0);
        rst_n = 1'b1;
        tick();

        nominal_load();
        play(3, 0, 1, 1'b0, 1'b0, 0, 0, 0);
        play(3, 3, 1, 1'b0, 1'b0, 0, 0, 0);

        // Illegal starts and abort beating start: monitor sees nothing.
        num_steps = '0; start = 1'b1; tick(); start = 1'b0; tick();
        chk("nstep0_busy", busy, 0);
        num_steps = 5'd17; start = 1'b1; tick(); start = 1'b0; tick();
        chk("nstep17_busy", busy, 0);
        num_steps = 5'd3; start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0; tick();
        chk("abort_start_busy", busy, 0);

        play(3, 0, 1, 1'b1, 1'b0, 0, 0, 0);
        play(3, 0, 1, 1'b0, 1'b0, 0, 0, 0);

        // Reset in the middle of step 2.
        begin
            exp_t e;
            for (int s = 0; s < 3; s++)
                for (int c = 0; c <= int'(m_hold[s]); c++) begin
                    e.data = m_data[s]; e.idx = AW'(s); e.fin = (s == 2 && c == int'(m_hold[s]));
                    exp_q.push_back(e);
                end
        end
        num_steps = 5'd3; start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ch_out", ch_out, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_valid", ch_valid, 0);
        chk("midrst_step_idx", step_idx, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        play(3, 0, 1, 1'b0, 1'b0, 0, 0, 0);
        if (reps_max > 1) play(3, 0, 3, 1'b0, 1'b0, 0, 0, 0);

        // Maximum hold, and write-to-step-0 in the start cycle.
        write(0, 5'h11, 255);
        play(1, 0, 1, 1'b0, 1'b0, 0, 0, 0);
        play(2, 0, 1, 1'b0, 1'b1, 0, 5'h07, 1);

        for (int a = 0; a < DEPTH; a++) write(a, $urandom_range(0, 31), $urandom_range(0, 4));
        for (int it = 0; it < 30; it++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++)
                write($urandom_range(0, DEPTH-1), $urandom_range(0, 31), $urandom_range(0, 4));
            play($urandom_range(1, DEPTH), ($urandom_range(0, 3) == 0) ? -1 : 0,
                 $urandom_range(1, reps_max), 1'b0, ($urandom_range(0, 4) == 0),
                 $urandom_range(0, 2), $urandom_range(0, 31), $urandom_range(0, 3));
        end

        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
